led_strip_driver: RTL and testbench
===================================

LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, pixel-RAM address width, legal range 4-10.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, bits per pixel word (GRB), legal range 8-32.
REQ-003 SHALL have parameter LED_NUM, default 16, pixels per frame, legal range 1 to 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 0, pixel-RAM read latency in cycles (0 = unregistered output, 1 = registered output).
REQ-005 SHALL have parameters T0H=20, T1H=40, TBIT=62, TRST=15000: cycle counts for 0-bit high time, 1-bit high time, bit period and latch gap.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle frame request.
REQ-009 SHALL have port rd_addr, output, ADDR_WIDTH, pixel-RAM read address.
REQ-010 SHALL have port rd_data, input, DATA_WIDTH, pixel-RAM read data.
REQ-011 SHALL have port busy, output, 1, high from frame acceptance until the end of the latch gap.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at the end of the latch gap.
REQ-013 SHALL have port led_dout, output, 1, one-wire serial LED data.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, SHIFT and LATCH.
REQ-015 SHALL, in IDLE with start=1, set rd_addr=0, assert busy on the next cycle and enter FETCH; start SHALL be ignored while busy=1.
REQ-016 SHALL stay in FETCH for RD_LATENCY+1 cycles, then load rd_data into the shift register and enter SHIFT.
REQ-017 SHALL transmit the shift register MSB-first, one bit per TBIT cycles: led_dout high for T1H cycles for a 1 and T0H cycles for a 0, low for the rest of the period.
REQ-018 SHALL, at the first cycle of the last bit of a non-final pixel, increment rd_addr and load the next word at that bit's final cycle, so pixels are sent with no gap between them.
REQ-019 SHALL, after the last bit of pixel LED_NUM-1, enter LATCH with led_dout=0 for TRST cycles, then pulse done, deassert busy in the same cycle, and return to IDLE.
REQ-020 SHALL hold rd_addr constant outside the points at which REQ-015 and REQ-018 change it, and SHALL never drive it to LED_NUM or above.
REQ-021 SHALL size the bit-timer, bit-index and pixel counters as clog2 of their maximum count plus one; no counter wraps within a frame.
REQ-022 SHALL treat as illegal any parameter set where T0H < T1H < TBIT or TBIT > RD_LATENCY+2 does not hold, and flag it with an elaboration-time check.

Reset
REQ-023 SHALL, on rst=1, force state IDLE, rd_addr=0, busy=0, done=0, led_dout=0 and all counters to 0 on the next edge, including mid-frame.
REQ-024 SHALL let rst take priority over start when both are asserted in the same cycle.

Configuration
REQ-025 SHALL, when macro LED_AUTO_REFRESH_EN is defined, go from LATCH directly to FETCH with rd_addr=0 after pulsing done, keeping busy high, so frames repeat without start.
REQ-026 SHALL, without LED_AUTO_REFRESH_EN, behave exactly as REQ-019: one frame per start.

Structure
REQ-027 SHALL place the FSM state enum and the default timing constants (T0H, T1H, TBIT, TRST) in the shared package led_drv_pkg.
REQ-028 SHALL put the per-bit waveform timer in the sub-module led_bit_encoder (inputs bit_val and go; outputs dout and bit_done).

Verification
REQ-029 SHALL cover: LED_NUM=2, RD_LATENCY=0, RAM words 24'hFF0000 and 24'h000001 -> 48 bits decoded exactly, 8 ones then 39 zeros then 1 one; done exactly TRST cycles after the last bit.
REQ-030 SHALL cover: RD_LATENCY=1, same data -> identical led_dout waveform, with the frame start shifted by one cycle.
REQ-031 SHALL cover: start pulsed again during SHIFT -> ignored; exactly one done per accepted start.
REQ-032 SHALL cover: rst asserted at bit 10 of pixel 0 -> led_dout=0, busy=0 and rd_addr=0 the next cycle; a new start sends a complete frame.
REQ-033 SHALL cover: high-time measurement with T0H=20, T1H=40, TBIT=62 -> every high pulse is exactly 20 or 40 cycles, and every bit period is exactly 62 cycles, including across pixel boundaries.
REQ-034 SHALL cover: LED_AUTO_REFRESH_EN defined, one start -> continuous frames, a done pulse every frame, busy never deasserts.

Source files
------------

// File: rtl/led_drv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_drv_pkg
// Description : Shared FSM state encoding, default one-wire LED timing
//               constants and counter-width helper for the LED strip driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_drv_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } led_state_e;

    // Default waveform timing in clock cycles
    localparam int DEF_T0H  = 20;
    localparam int DEF_T1H  = 40;
    localparam int DEF_TBIT = 62;
    localparam int DEF_TRST = 15000;

    // Bits needed to hold 0..max_count (never less than one bit)
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : led_bit_encoder
// Description : Per-bit one-wire waveform timer. While go is held high it
//               produces back-to-back bit periods of TBIT cycles; dout is
//               high for T1H (bit_val=1) or T0H (bit_val=0) cycles at the
//               start of each period. bit_done flags a period's last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bit_encoder
    import led_drv_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic dout,
    output logic bit_done
);

    localparam int                 c_CNT_W = cnt_width(TBIT - 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TBIT - 1);
    localparam logic [c_CNT_W-1:0] c_HI0   = c_CNT_W'(T0H);
    localparam logic [c_CNT_W-1:0] c_HI1   = c_CNT_W'(T1H);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_bit_done;

    assign w_bit_done = go && (r_cnt == c_LAST);
    assign bit_done   = w_bit_done;
    // Bit value comes from a register, so dout only changes just after an edge
    assign dout       = go && (r_cnt < (bit_val ? c_HI1 : c_HI0));

    // Position within the current bit period; parked at zero while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!go || w_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_strip_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_strip_driver
// Description : Reads LED_NUM pixel words from an external pixel RAM and
//               streams them MSB-first as a one-wire LED waveform, followed
//               by a TRST-cycle latch gap and a done pulse.
// Config      : LED_AUTO_REFRESH_EN - when defined, the latch gap is followed
//               directly by a new frame (busy stays high, frames repeat).
// Revision    : 1.0 - initial release
// ============================================================================
module led_strip_driver
    import led_drv_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 24,
    parameter int LED_NUM    = 16,
    parameter int RD_LATENCY = 0,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TRST       = DEF_TRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  led_dout
);

    localparam int c_FETCH_W = cnt_width(RD_LATENCY);
    localparam int c_BIT_W   = cnt_width(DATA_WIDTH - 1);
    localparam int c_PIX_W   = cnt_width(LED_NUM - 1);
    localparam int c_LAT_W   = cnt_width(TRST - 1);

    localparam logic [c_FETCH_W-1:0] c_FETCH_LAST = c_FETCH_W'(RD_LATENCY);
    localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]   c_BIT_PENULT = c_BIT_W'(DATA_WIDTH - 2);
    localparam logic [c_PIX_W-1:0]   c_PIX_LAST   = c_PIX_W'(LED_NUM - 1);
    localparam logic [c_LAT_W-1:0]   c_LAT_LAST   = c_LAT_W'(TRST - 1);

    // Reject parameter sets the timing scheme cannot honour
    generate
        if (!(T0H < T1H && T1H < TBIT && TBIT > RD_LATENCY + 2)) begin : g_bad_timing
            $error("led_strip_driver: need T0H < T1H < TBIT and TBIT > RD_LATENCY+2");
        end
        if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10 || DATA_WIDTH < 8 || DATA_WIDTH > 32 ||
            LED_NUM < 1 || LED_NUM > (1 << ADDR_WIDTH) ||
            RD_LATENCY < 0 || RD_LATENCY > 1 || TRST < 1) begin : g_bad_range
            $error("led_strip_driver: parameter outside legal range");
        end
    endgenerate

    led_state_e              r_state;
    led_state_e              w_next_state;
    logic [c_FETCH_W-1:0]    r_fetch_cnt;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_PIX_W-1:0]      r_pix_cnt;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_busy;
    logic                    r_done;

    logic w_go;
    logic w_bit_done;
    logic w_fetch_done;
    logic w_last_bit;
    logic w_last_pix;
    logic w_latch_done;

    assign w_go         = (r_state == ST_SHIFT);
    assign w_fetch_done = (r_state == ST_FETCH) && (r_fetch_cnt == c_FETCH_LAST);
    assign w_last_bit   = (r_bit_cnt == c_BIT_LAST);
    assign w_last_pix   = (r_pix_cnt == c_PIX_LAST);
    assign w_latch_done = (r_state == ST_LATCH) && (r_lat_cnt == c_LAT_LAST);

    assign rd_addr = r_addr;
    assign busy    = r_busy;
    assign done    = r_done;

    led_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_enc (
        .clk      (clk),
        .rst      (rst),
        .go       (w_go),
        .bit_val  (r_shreg[DATA_WIDTH-1]),
        .dout     (led_dout),
        .bit_done (w_bit_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_fetch_done) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_bit_done && w_last_bit && w_last_pix) begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (w_latch_done) begin
`ifdef LED_AUTO_REFRESH_EN
                    w_next_state = ST_FETCH;
`else
                    w_next_state = ST_IDLE;
`endif
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Counters, shift register, read address and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_bit_cnt   <= '0;
            r_pix_cnt   <= '0;
            r_lat_cnt   <= '0;
            r_shreg     <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_addr      <= '0;
                        r_fetch_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_done) begin
                        r_shreg     <= rd_data;
                        r_fetch_cnt <= '0;
                        r_bit_cnt   <= '0;
                        r_pix_cnt   <= '0;
                    end else begin
                        r_fetch_cnt <= r_fetch_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_bit_done) begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (!w_last_pix) begin
                                // Next word has been addressed for a whole bit period
                                r_shreg   <= rd_data;
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                            end
                        end else begin
                            r_shreg   <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            // Advance the address as the last bit starts, giving the RAM time to respond
                            if (r_bit_cnt == c_BIT_PENULT && !w_last_pix) begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_latch_done) begin
                        r_done    <= 1'b1;
                        r_lat_cnt <= '0;
`ifdef LED_AUTO_REFRESH_EN
                        r_addr      <= '0;
                        r_fetch_cnt <= '0;
`else
                        r_busy    <= 1'b0;
`endif
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_strip_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_strip_driver
// Description : Self-checking bench for led_strip_driver. Frames are issued
//               with random pixel data; the expected bit stream of each
//               accepted frame is queued, and a monitor decodes led_dout by
//               pulse width and compares every completed frame, bit period,
//               high time and done timing.
// Config      : LED_AUTO_REFRESH_EN selects the repeating-frame scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_strip_driver;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 24;
    localparam int LED_N      = 2;
    localparam int RD_LAT     = 1;
    localparam int T0H        = 20;
    localparam int T1H        = 40;
    localparam int TBIT       = 62;
    localparam int TRST       = 500;
    localparam int FRAME_BITS = DATA_W * LED_N;
    localparam int WAIT_MAX   = 20000;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              led_dout;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_q;

    int          total = 0;
    int          bad   = 0;
    longint      cyc   = 0;
    logic [63:0] exp_q[$];

    int          done_cnt    = 0;
    int          mon_nbits   = 0;
    int          max_addr    = 0;
    int          busy_low    = 0;
    bit          auto_run    = 1'b0;
    bit          lat_pending = 1'b0;
    longint      start_cyc   = 0;

    led_strip_driver #(
        .ADDR_WIDTH (ADDR_W),
        .DATA_WIDTH (DATA_W),
        .LED_NUM    (LED_N),
        .RD_LATENCY (RD_LAT),
        .T0H        (T0H),
        .T1H        (T1H),
        .TBIT       (TBIT),
        .TRST       (TRST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .led_dout (led_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel RAM model, registered or unregistered read
    always @(posedge clk) rd_q <= ram[rd_addr];
    assign rd_data = (RD_LAT != 0) ? rd_q : ram[rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_ram();
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = DATA_W'($urandom());
    endtask

    // Reference: the frame is simply the pixel words in address order, MSB first
    function automatic logic [63:0] frame_of();
        logic [63:0] f = '0;
        for (int p = 0; p < LED_N; p++) f = (f << DATA_W) | 64'(ram[p]);
        return f;
    endfunction

    task automatic issue_start();
        start       = 1'b1;
        start_cyc   = cyc;
        lat_pending = 1'b1;
        exp_q.push_back(frame_of());
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check("done_arrived", 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_bits(input int nb);
        int n = 0;
        while (!(mon_nbits >= nb && led_dout) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check("reached_bit", 64'(mon_nbits), 64'(nb));
    endtask

    // Monitor: decode led_dout by pulse width and score completed frames
    initial begin
        longint      last_rise = -1;
        longint      hi;
        bit          prev_led  = 1'b0;
        logic [63:0] acc       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_nbits = 0;
                acc       = '0;
                prev_led  = 1'b0;
                last_rise = -1;
            end else begin
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                if (auto_run && !busy) busy_low++;
                if (led_dout && !prev_led) begin
                    if (mon_nbits > 0) check("bit_period", 64'(cyc - last_rise), 64'(TBIT));
                    if (lat_pending) begin
                        check("start_latency", 64'(cyc - start_cyc), 64'(RD_LAT + 2));
                        lat_pending = 1'b0;
                    end
                    last_rise = cyc;
                end
                if (!led_dout && prev_led) begin
                    hi = cyc - last_rise;
                    total++;
                    if (hi != T0H && hi != T1H) begin
                        bad++;
                        $display("FAIL high_time: got %0d cycles expected %0d or %0d", hi, T0H, T1H);
                    end
                    acc = {acc[62:0], (hi == T1H)};
                    mon_nbits++;
                    if (mon_nbits == FRAME_BITS) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame_data: got unexpected frame 0x%0h expected none", acc);
                        end else begin
                            check("frame_data", acc, exp_q.pop_front());
                        end
                        mon_nbits = 0;
                        acc       = '0;
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_timing", 64'(cyc - last_rise), 64'(TBIT + TRST));
`ifdef LED_AUTO_REFRESH_EN
                    check("busy_at_done", 64'(busy), 64'd1);
`else
                    check("busy_at_done", 64'(busy), 64'd0);
`endif
                end
                prev_led = led_dout;
            end
        end
    end

    // Global cycle bound
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int target = 0;
        fill_ram();
        tick(3);
        check("rst_led_dout", 64'(led_dout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        tick(2);

        // Directed frame: 8 ones, 39 zeros, 1 one
        ram[0] = 24'hFF0000;
        ram[1] = 24'h000001;

`ifdef LED_AUTO_REFRESH_EN
        auto_run = 1'b1;
        issue_start();
        exp_q.push_back(frame_of());
        exp_q.push_back(frame_of());
        wait_done(3);
        auto_run = 1'b0;
        check("auto_busy_low_cycles", 64'(busy_low), 64'd0);
        check("auto_frames_scored", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        lat_pending = 1'b0;
        tick(2);
        check("auto_rst_busy", 64'(busy), 64'd0);
`else
        issue_start();
        target++;
        wait_done(target);

        // Random frames with a spurious start pulse during shifting
        for (int i = 0; i < 4; i++) begin
            fill_ram();
            tick($urandom_range(1, 20));
            issue_start();
            target++;
            wait_bits($urandom_range(1, FRAME_BITS - 2));
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(target);
            check("no_done_after_frame", 64'(done), 64'd0);
        end

        // Reset in the middle of bit 10 of pixel 0
        fill_ram();
        tick(3);
        issue_start();
        wait_bits(10);
        rst = 1'b1;
        tick();
        check("midrst_led_dout", 64'(led_dout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rd_addr", 64'(rd_addr), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        lat_pending = 1'b0;
        tick(4);

        fill_ram();
        issue_start();
        target++;
        wait_done(target);
        tick(10);
        check("done_count", 64'(done_cnt), 64'(target));
        check("expected_queue_empty", 64'(exp_q.size()), 64'd0);
        check("max_rd_addr", 64'(max_addr), 64'(LED_N - 1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
